// File: rtl/npc_trap.sv
// Next-PC selection with a nested, priority-preemptive trap stack of {epc, cause} pairs.
// Index 0 of int_req is the highest-priority source.
module npc_trap #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned NUM_SRC   = 8,
   parameter int unsigned DEPTH     = 4,
   parameter bit          VECTORED  = 1'b1,
   parameter logic [XLEN-1:0] TVEC_BASE = 32'h0000_0a7c,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [XLEN-1:0]                pc,
   input  logic [XLEN-1:0]                pc_ex,
   input  logic [2:0]                     npc_op,
   input  logic [XLEN-1:0]                imm,
   input  logic [XLEN-1:0]                aluout,
   input  logic                           pc_write,
   input  logic [NUM_SRC-1:0]             int_req,
   input  logic [NUM_SRC-1:0]             int_mask,
   input  logic                           trap_ret,
   output logic [XLEN-1:0]                npc,
   output logic                           trap_taken,
   output logic [$clog2(NUM_SRC)-1:0]     cause,
   output logic [XLEN-1:0]                epc,
   output logic [$clog2(DEPTH+1)-1:0]     depth,
   output logic                           in_trap,
   output logic                           stack_ovf
);

   localparam int unsigned CW    = $clog2(NUM_SRC);
   localparam int unsigned DW    = $clog2(DEPTH + 1);
   localparam int unsigned IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned SLOTS = 2 ** IW;
   localparam logic [DW-1:0] DepthMax = DW'(DEPTH);

   logic [XLEN-1:0]    epc_q   [SLOTS];
   logic [CW-1:0]      cause_q [SLOTS];
   logic [DW-1:0]      depth_q;
   logic               stack_ovf_q;

   logic [NUM_SRC-1:0] pending;
   logic [CW-1:0]      sel;
   logic [IW-1:0]      top_idx;
   logic [IW-1:0]      push_idx;
   logic [XLEN-1:0]    top_epc;
   logic [CW-1:0]      top_cause;
   logic               empty;
   logic               preempt;
   logic               do_pop;
   logic               do_push;
   logic               do_ovf;
   logic [XLEN-1:0]    vec_addr;

   assign pending  = int_req & int_mask;
   assign empty    = (depth_q == '0);
   assign top_idx  = IW'(depth_q - DW'(1));
   assign push_idx = IW'(depth_q);

   always_comb begin
      sel = '0;
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
         if (pending[i]) sel = CW'(i);
      end
   end

   assign top_epc   = empty ? '0 : epc_q[top_idx];
   assign top_cause = empty ? '0 : cause_q[top_idx];

   assign preempt = (pending != '0) && (empty || (sel < top_cause));

   // A return always wins the cycle; pending requests are re-judged against the new top.
   assign do_pop  = !rst && pc_write && trap_ret && !empty;
   assign do_push = !rst && pc_write && !do_pop && preempt && (depth_q < DepthMax);
   assign do_ovf  = !rst && pc_write && !do_pop && preempt && (depth_q == DepthMax);

   assign vec_addr = VECTORED ? (TVEC_BASE + (XLEN'(sel) << 2)) : TVEC_BASE;

   always_comb begin
      npc = pc + XLEN'(4);
      if (rst) begin
         npc = RESET_PC;
      end else if (!pc_write) begin
         npc = pc;
      end else if (do_pop) begin
         npc = top_epc + XLEN'(4);
      end else if (do_push) begin
         npc = vec_addr;
      end else begin
         unique case (npc_op)
            3'b001, 3'b010: npc = pc_ex + imm;
            3'b100:         npc = {aluout[XLEN-1:1], 1'b0};
            default:        npc = pc + XLEN'(4);
         endcase
      end
   end

   assign trap_taken = do_push;

   always_ff @(posedge clk) begin
      if (rst) begin
         depth_q     <= '0;
         stack_ovf_q <= 1'b0;
      end else begin
         if (do_push) begin
            epc_q[push_idx]   <= pc_ex;
            cause_q[push_idx] <= sel;
            depth_q           <= depth_q + DW'(1);
         end else if (do_pop) begin
            depth_q <= depth_q - DW'(1);
         end
         if (do_ovf) stack_ovf_q <= 1'b1;
      end
   end

   assign cause     = top_cause;
   assign epc       = top_epc;
   assign depth     = depth_q;
   assign in_trap   = !empty;
   assign stack_ovf = stack_ovf_q;

endmodule

// File: tb/tb_npc_trap.sv
// Self-checking bench for npc_trap: vector table plus hand-written nesting/overflow/reset runs,
// with expected results queued as stimulus is applied and compared once outputs settle.
module tb_npc_trap;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc, pc_ex, imm, aluout;
   logic [2:0]  npc_op;
   logic        pc_write;
   logic [7:0]  int_req, int_mask;
   logic        trap_ret;
   logic [31:0] npc;
   logic        trap_taken;
   logic [2:0]  cause;
   logic [31:0] epc;
   logic [2:0]  depth;
   logic        in_trap;
   logic        stack_ovf;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic        pw;
      logic        tret;
      logic [2:0]  op;
      logic [31:0] pc;
      logic [31:0] pc_ex;
      logic [31:0] imm;
      logic [31:0] alu;
      logic [7:0]  req;
      logic [7:0]  mask;
      logic [31:0] e_npc;
      logic        e_taken;
      logic [2:0]  e_depth;
      logic [2:0]  e_cause;
      logic [31:0] e_epc;
      logic        e_ovf;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];

   npc_trap dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .pc_ex      (pc_ex),
      .npc_op     (npc_op),
      .imm        (imm),
      .aluout     (aluout),
      .pc_write   (pc_write),
      .int_req    (int_req),
      .int_mask   (int_mask),
      .trap_ret   (trap_ret),
      .npc        (npc),
      .trap_taken (trap_taken),
      .cause      (cause),
      .epc        (epc),
      .depth      (depth),
      .in_trap    (in_trap),
      .stack_ovf  (stack_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL step %0d %s: got 0x%08h, expected 0x%08h", idx, name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic pw, input logic tr, input logic [2:0] op,
                               input logic [31:0] p, input logic [31:0] px, input logic [31:0] im,
                               input logic [31:0] al, input logic [7:0] rq, input logic [7:0] mk_,
                               input logic [31:0] en, input logic et, input logic [2:0] ed,
                               input logic [2:0] ec, input logic [31:0] ee, input logic eo);
      vec_t v;
      v.rst = r; v.pw = pw; v.tret = tr; v.op = op; v.pc = p; v.pc_ex = px; v.imm = im;
      v.alu = al; v.req = rq; v.mask = mk_; v.e_npc = en; v.e_taken = et; v.e_depth = ed;
      v.e_cause = ec; v.e_epc = ee; v.e_ovf = eo;
      return v;
   endfunction

   // Drive one cycle's inputs after the falling edge, queue the expectation, compare before
   // the rising edge commits any stack change.
   task automatic step(input vec_t v, input int idx);
      vec_t e;
      @(negedge clk);
      rst = v.rst; pc_write = v.pw; trap_ret = v.tret; npc_op = v.op; pc = v.pc;
      pc_ex = v.pc_ex; imm = v.imm; aluout = v.alu; int_req = v.req; int_mask = v.mask;
      sb.push_back(v);
      #2;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL step %0d scoreboard: got empty queue, expected one entry", idx);
      end else begin
         e = sb.pop_front();
         check("npc", idx, npc, e.e_npc);
         check("trap_taken", idx, {31'b0, trap_taken}, {31'b0, e.e_taken});
         check("depth", idx, {29'b0, depth}, {29'b0, e.e_depth});
         check("cause", idx, {29'b0, cause}, {29'b0, e.e_cause});
         check("epc", idx, epc, e.e_epc);
         check("in_trap", idx, {31'b0, in_trap}, {31'b0, (e.e_depth != 3'd0)});
         check("stack_ovf", idx, {31'b0, stack_ovf}, {31'b0, e.e_ovf});
      end
   endtask

   localparam logic [2:0] P4 = 3'b000, BR = 3'b001, JP = 3'b010, JR = 3'b100;

   initial begin
      rst = 1'b1; pc_write = 1'b1; trap_ret = 1'b0; npc_op = P4; pc = '0; pc_ex = '0;
      imm = '0; aluout = '0; int_req = '0; int_mask = '0;
      repeat (2) @(posedge clk);

      // Normal flow, single trap entry/return, nesting, stall and conflict.
      vecs.push_back(mk(1,1,0,P4,32'h123,0,0,0,8'hff,8'hff, 32'h0,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,P4,32'h100,0,0,0,0,0, 32'h104,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,BR,0,32'h200,32'hffff_fff0,0,0,0, 32'h1f0,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,JP,0,32'h10,32'h20,0,0,0, 32'h30,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,JR,0,0,0,32'h333,0,0, 32'h332,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,3'b011,32'h50,0,0,0,0,0, 32'h54,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,P4,32'hffff_fffc,0,0,0,0,0, 32'h0,0,0,0,0,0));
      vecs.push_back(mk(0,1,1,P4,32'h80,0,0,0,0,0, 32'h84,0,0,0,0,0));
      vecs.push_back(mk(0,1,0,P4,32'h404,32'h400,0,0,8'h08,8'h08, 32'ha88,1,0,0,0,0));
      vecs.push_back(mk(0,1,0,P4,32'ha88,0,0,0,0,0, 32'ha8c,0,1,3,32'h400,0));
      vecs.push_back(mk(0,1,0,P4,32'ha8c,32'h500,0,0,8'h02,8'hff, 32'ha80,1,1,3,32'h400,0));
      vecs.push_back(mk(0,1,0,P4,32'ha80,0,0,0,8'h20,8'hff, 32'ha84,0,2,1,32'h500,0));
      vecs.push_back(mk(0,1,0,P4,32'ha84,0,0,0,8'h02,8'hff, 32'ha88,0,2,1,32'h500,0));
      vecs.push_back(mk(0,1,1,P4,32'ha88,0,0,0,0,0, 32'h504,0,2,1,32'h500,0));
      vecs.push_back(mk(0,1,0,P4,32'h504,0,0,0,0,0, 32'h508,0,1,3,32'h400,0));
      vecs.push_back(mk(0,1,0,P4,32'h508,0,0,0,8'h01,8'h00, 32'h50c,0,1,3,32'h400,0));
      vecs.push_back(mk(0,0,0,P4,32'h600,32'h650,0,0,8'h01,8'hff, 32'h600,0,1,3,32'h400,0));
      vecs.push_back(mk(0,1,1,P4,32'h600,32'h650,0,0,8'h01,8'hff, 32'h404,0,1,3,32'h400,0));
      vecs.push_back(mk(0,1,0,P4,32'h404,32'h700,0,0,8'h01,8'hff, 32'ha7c,1,0,0,0,0));
      vecs.push_back(mk(0,1,0,P4,32'ha7c,0,0,0,0,0, 32'ha80,0,1,0,32'h700,0));
      vecs.push_back(mk(0,1,1,P4,32'ha80,0,0,0,0,0, 32'h704,0,1,0,32'h700,0));
      vecs.push_back(mk(0,1,0,P4,32'h704,0,0,0,0,0, 32'h708,0,0,0,0,0));

      for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

      // Fill the stack with causes 7..4, then a higher-priority request is refused.
      step(mk(0,1,0,P4,32'h2000,32'h1000,0,0,8'h80,8'hff, 32'ha98,1,0,0,0,0), 100);
      step(mk(0,1,0,P4,32'h2000,32'h1004,0,0,8'h40,8'hff, 32'ha94,1,1,7,32'h1000,0), 101);
      step(mk(0,1,0,P4,32'h2000,32'h1008,0,0,8'h20,8'hff, 32'ha90,1,2,6,32'h1004,0), 102);
      step(mk(0,1,0,P4,32'h2000,32'h100c,0,0,8'h10,8'hff, 32'ha8c,1,3,5,32'h1008,0), 103);
      step(mk(0,1,0,P4,32'h2000,32'h2100,0,0,8'h04,8'hff, 32'h2004,0,4,4,32'h100c,0), 104);
      step(mk(0,1,0,P4,32'h2004,0,0,0,0,0, 32'h2008,0,4,4,32'h100c,1), 105);
      step(mk(0,1,1,P4,32'h2008,0,0,0,0,0, 32'h1010,0,4,4,32'h100c,1), 106);
      step(mk(0,1,0,P4,32'h10,0,0,0,0,0, 32'h14,0,3,5,32'h1008,1), 107);

      // Reset at depth 3 discards every context and clears the sticky overflow.
      step(mk(1,1,1,JR,32'h40,32'h44,0,32'h99,8'h01,8'hff, 32'h0,0,3,5,32'h1008,1), 200);
      step(mk(0,1,0,P4,32'h40,0,0,0,0,0, 32'h44,0,0,0,0,0), 201);
      step(mk(0,1,1,P4,32'h44,0,0,0,0,0, 32'h48,0,0,0,0,0), 202);

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/npc_trap.md
# npc_trap

Parametrised next-PC unit with a nested, priority-preemptive trap stack. Each cycle it selects the next fetch address from sequential, branch, jump, JALR, trap-vector and trap-return sources. It holds a DEPTH-entry stack of {EPC, cause} pairs so a higher-priority interrupt can preempt a running handler and return correctly. It sits between the EX-stage control and the PC register: PC loads `npc` every cycle.

## Interface
- XLEN, 32, address/data width
- NUM_SRC, 8, number of interrupt/exception sources (≥2); index 0 = highest priority
- DEPTH, 4, trap-stack entries (≥1)
- VECTORED, 1, 1: vector = TVEC_BASE + 4·cause; 0: all traps go to TVEC_BASE
- TVEC_BASE, 32'h0000_0a7c, trap vector base
- RESET_PC, 32'h0000_0000, `npc` while `rst` is asserted

Ports (CW = $clog2(NUM_SRC), DW = $clog2(DEPTH+1)):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- pc  in  XLEN  current fetch PC
- pc_ex  in  XLEN  PC of the instruction in EX
- npc_op  in  3  000 PLUS4, 001 BRANCH, 010 JUMP, 100 JALR, others treated as PLUS4
- imm  in  XLEN  branch/jump offset
- aluout  in  XLEN  JALR target
- pc_write  in  1  PC update enable; 0 = stall
- int_req  in  NUM_SRC  level-sensitive trap requests
- int_mask  in  NUM_SRC  per-source enable
- trap_ret  in  1  return-from-trap instruction in EX
- npc  out  XLEN  next PC (combinational)
- trap_taken  out  1  trap entry this cycle (combinational)
- cause  out  CW  cause at stack top; 0 when empty
- epc  out  XLEN  EPC at stack top; 0 when empty
- depth  out  DW  occupied entries
- in_trap  out  1  depth != 0
- stack_ovf  out  1  sticky: trap refused because the stack was full

## Operation
- pending = int_req & int_mask. sel = lowest set index of pending.
- Preempt condition: pending != 0 AND (depth == 0 OR sel < cause).
- Priority of actions when pc_write = 1, highest first:
  1. trap_ret with depth > 0: pop the stack; npc = popped epc + 4. Interrupts are not taken this cycle and are re-evaluated next cycle against the new top.
  2. Preempt condition with depth < DEPTH: push {pc_ex, sel}; npc = VECTORED ? TVEC_BASE + (sel << 2) : TVEC_BASE; trap_taken = 1.
  3. Preempt condition with depth == DEPTH: no push; set stack_ovf; fall through to rule 4.
  4. Normal flow:
     - PLUS4: pc + 4
     - BRANCH and JUMP: pc_ex + imm
     - JALR: aluout with bit 0 cleared
- trap_ret with depth == 0 is ignored; normal flow applies.
- Equal or lower-priority pending requests while in a trap wait for the handler to return. No state change; no stack_ovf.
- pc_write = 0: npc = pc, trap_taken = 0, no push, pop or ovf update.
- All address arithmetic is modulo 2^XLEN (wrap, no carry out).
- Stack is LIFO. Entries above depth are don't-care, but cause/epc read 0 when depth == 0.

## Timing
- npc and trap_taken are zero-latency combinational functions of the inputs and current stack state.
- Push, pop, depth and stack_ovf update on the rising clk edge of the accepting cycle; cause/epc/depth reflect the change the next cycle.
- rst = 1 (synchronous):
  - next edge sets depth = 0 and stack_ovf = 0.
  - While rst is high: npc = RESET_PC, trap_taken = 0. All other inputs are ignored.
- rst mid-handler discards all stacked contexts; no return is possible afterwards.
- stack_ovf clears only on rst.

## Test plan
- Sequential/branch/JALR:
  - pc = 0x100, PLUS4 → npc 0x104.
  - pc_ex = 0x200, imm = 0xFFFFFFF0, BRANCH → npc 0x1F0.
  - JALR, aluout = 0x333 → npc 0x332.
  - pc = 0xFFFFFFFC, PLUS4 → npc 0x0.
- Trap entry/return: int_req = int_mask = 0x08, pc_ex = 0x400 → trap_taken = 1, npc = 0xA88. Next cycle depth = 1, cause = 3, epc = 0x400. trap_ret → npc 0x404; next cycle depth = 0.
- Nesting:
  - In cause 3, raise source 1 at pc_ex = 0x500 → push, npc = 0xA80, depth = 2.
  - Raise source 5 → not taken.
  - trap_ret → npc 0x504, cause back to 3.
- Overflow: DEPTH = 4, take causes 7, 6, 5, 4, then raise source 2 → trap_taken = 0, normal npc, stack_ovf = 1 next cycle and stays 1 until rst.
- Stall and conflict:
  - pc_write = 0 with pending request → npc = pc, depth unchanged.
  - trap_ret and a higher-priority request in the same cycle → pop only; trap taken the following cycle.
- Reset: assert rst at depth 3 → npc = RESET_PC during rst; after the edge depth = 0, in_trap = 0, stack_ovf = 0, cause = 0, epc = 0.
